// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

   typedef enum logic {CLEAR, SERVE} mem_state_t;

   localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response bus, loader port and status, bundled for the responder.
interface mem_responder_if #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16
);

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] mem_in;
   logic                  load_valid;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_ready;
   logic                  ready;
   logic [15:0]           wr_count;

   modport master (
      output mem_we, mem_addr, mem_data, load_valid, load_addr, load_data,
      input  mem_in, load_ready, ready, wr_count
   );

   modport slave (
      input  mem_we, mem_addr, mem_data, load_valid, load_addr, load_data,
      output mem_in, load_ready, ready, wr_count
   );

endinterface

// File: rtl/mem_array.sv
// Single write port, single registered read port storage; reads are write-first.
module mem_array #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [Depth];

   // Storage has no reset; the responder's clear sequence zeroes it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// CPU memory responder: zero-clears the array after reset, then serves CPU
// reads/writes with a lower-priority loader write port.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16
) (
   input logic            clk,
   input logic            rst,
   mem_responder_if.slave bus
);

   mem_state_t            state_q, state_d;
   logic [ADDR_WIDTH:0]   clr_ptr_q, clr_ptr_d;
   logic [15:0]           wr_count_q, wr_count_d;
   logic                  serving;
   logic                  arr_we;
   logic [ADDR_WIDTH-1:0] arr_addr;
   logic [DATA_WIDTH-1:0] arr_data;

   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      wr_count_d = wr_count_q;
      serving    = 1'b0;
      arr_we     = 1'b0;
      arr_addr   = bus.mem_addr;
      arr_data   = bus.mem_data;
      bus.load_ready = 1'b0;

      unique case (state_q)
         CLEAR: begin
            arr_we    = 1'b1;
            arr_addr  = clr_ptr_q[ADDR_WIDTH-1:0];
            arr_data  = '0;
            clr_ptr_d = clr_ptr_q + (ADDR_WIDTH + 1)'(1);
            // Top bit set means the last address was just written.
            if (clr_ptr_d[ADDR_WIDTH]) begin
               state_d = SERVE;
            end
         end
         SERVE: begin
            serving = 1'b1;
            if (bus.mem_we) begin
               arr_we = 1'b1;
            end else if (bus.load_valid) begin
               arr_we         = 1'b1;
               arr_addr       = bus.load_addr;
               arr_data       = bus.load_data;
               bus.load_ready = 1'b1;
            end
            if (arr_we && (wr_count_q != WR_COUNT_MAX)) begin
               wr_count_d = wr_count_q + 16'd1;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_ptr_q  <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         wr_count_q <= wr_count_d;
      end
   end

   mem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem_array (
      .clk     (clk),
      .rst     (rst),
      .we      (arr_we),
      .wr_addr (arr_addr),
      .wr_data (arr_data),
      .rd_en   (serving),
      .rd_addr (bus.mem_addr),
      .rd_data (bus.mem_in)
   );

   assign bus.ready    = serving;
   assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against an array/counter model.
module tb_mem_responder;

   localparam int unsigned Aw    = 6;
   localparam int unsigned Dw    = 16;
   localparam int unsigned Depth = 1 << Aw;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_responder_if #(.ADDR_WIDTH(Aw), .DATA_WIDTH(Dw)) bus ();

   mem_responder #(.ADDR_WIDTH(Aw), .DATA_WIDTH(Dw)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [Dw-1:0] model_mem [Depth];
   int            clear_left;
   logic [Dw-1:0] exp_mem_in;
   int            exp_count;
   bit            last_fire;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_mem_in", 32'(bus.mem_in), 0);
      check("rst_ready", 32'(bus.ready), 0);
      check("rst_wr_count", 32'(bus.wr_count), 0);
      check("rst_load_ready", 32'(bus.load_ready), 0);
      clear_left = Depth;
      exp_mem_in = '0;
      exp_count  = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One clock: check combinational handshake, advance model at the edge, check outputs.
   task automatic cycle();
      bit exp_lr;
      bit acc;
      exp_lr = (clear_left == 0) && bus.load_valid && !bus.mem_we;
      #1;
      check("load_ready", 32'(bus.load_ready), 32'(exp_lr));
      @(posedge clk);
      acc = 1'b0;
      if (clear_left > 0) begin
         clear_left--;
         if (clear_left == 0) begin
            for (int i = 0; i < Depth; i++) model_mem[i] = '0;
         end
      end else begin
         if (bus.mem_we) begin
            model_mem[bus.mem_addr] = bus.mem_data;
            acc = 1'b1;
         end else if (bus.load_valid) begin
            model_mem[bus.load_addr] = bus.load_data;
            acc = 1'b1;
         end
         exp_mem_in = model_mem[bus.mem_addr];
         if (acc && exp_count < 65535) exp_count++;
      end
      last_fire = exp_lr;
      #1;
      check("mem_in", 32'(bus.mem_in), 32'(exp_mem_in));
      check("wr_count", 32'(bus.wr_count), 32'(exp_count));
      check("ready", 32'(bus.ready), 32'(clear_left == 0));
   endtask

   task automatic idle(input logic [Aw-1:0] addr);
      bus.mem_we     = 1'b0;
      bus.mem_addr   = addr;
      bus.load_valid = 1'b0;
   endtask

   initial begin
      int n;
      int c0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_data   = '0;
      bus.load_valid = 1'b0;
      bus.load_addr  = '0;
      bus.load_data  = '0;
      last_fire      = 1'b0;
      for (int i = 0; i < Depth; i++) model_mem[i] = 'x;

      // Reset, then clear with CPU and loader requests that must be ignored.
      do_reset();
      bus.mem_we     = 1'b1;
      bus.mem_addr   = '0;
      bus.mem_data   = 16'hFFFF;
      bus.load_valid = 1'b1;
      bus.load_addr  = '0;
      bus.load_data  = 16'hFFFF;
      n = 0;
      while (!bus.ready && n < 200) begin
         cycle();
         n++;
      end
      check("clear_cycles", 32'(n), 64);
      idle('0);
      cycle();
      check("addr0_after_clear", 32'(bus.mem_in), 0);
      check("count_after_clear", 32'(bus.wr_count), 0);
      idle(6'd31);
      cycle();
      idle(6'd63);
      cycle();

      // CPU write then read, and write with same-cycle read.
      bus.mem_we   = 1'b1;
      bus.mem_addr = 6'd5;
      bus.mem_data = 16'hBEEF;
      cycle();
      check("write_first_5", 32'(bus.mem_in), 32'h0000BEEF);
      idle(6'd5);
      cycle();
      check("read_5", 32'(bus.mem_in), 32'h0000BEEF);

      // Loader held off by three CPU writes.
      c0 = int'(bus.wr_count);
      bus.load_valid = 1'b1;
      bus.load_addr  = 6'd10;
      bus.load_data  = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         bus.mem_we   = 1'b1;
         bus.mem_addr = 6'(20 + i);
         bus.mem_data = 16'(32'hA000 + i);
         cycle();
      end
      bus.mem_we   = 1'b0;
      bus.mem_addr = 6'd10;
      cycle();
      check("load_write_first", 32'(bus.mem_in), 32'h00001234);
      check("count_plus4", 32'(bus.wr_count), 32'(c0 + 4));
      idle(6'd10);
      cycle();

      // Random traffic; loader keeps its request stable until accepted.
      last_fire = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bus.mem_we   = ($urandom_range(0, 2) == 0);
         bus.mem_addr = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7))
                                                     : 6'($urandom_range(0, 63));
         bus.mem_data = 16'($urandom);
         if (!bus.load_valid || last_fire) begin
            bus.load_valid = ($urandom_range(0, 1) == 1);
            bus.load_addr  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7))
                                                          : 6'($urandom_range(0, 63));
            bus.load_data  = 16'($urandom);
         end
         cycle();
      end

      // Reset mid-serve, then again at cycle 20 of the clear.
      idle('0);
      do_reset();
      for (int i = 0; i < 20; i++) cycle();
      do_reset();
      for (int i = 0; i < Depth; i++) cycle();
      check("ready_after_reclear", 32'(bus.ready), 1);
      for (int i = 0; i < Depth; i++) begin
         idle(6'(i));
         cycle();
         check("rezeroed", 32'(bus.mem_in), 0);
      end

      // Drive the write counter into saturation.
      for (int i = 0; i < 65537; i++) begin
         bus.mem_we   = 1'b1;
         bus.mem_addr = 6'($urandom_range(0, 63));
         bus.mem_data = 16'($urandom);
         cycle();
      end
      check("count_saturated", 32'(bus.wr_count), 32'h0000FFFF);
      idle('0);
      cycle();
      check("count_still_sat", 32'(bus.wr_count), 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's data/instruction memory interface. It accepts the CPU's `mem_we` / `mem_addr` / `mem_data` requests and returns read data on `mem_in` with fixed one-cycle latency. After reset it zero-clears the whole array, then serves the CPU. A secondary load port lets a bench or boot loader write program words at lower priority than the CPU.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: word address width; depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 16: word width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_we`  in  1  CPU write enable.
- `mem_addr`  in  ADDR_WIDTH  CPU word address, for both read and write.
- `mem_data`  in  DATA_WIDTH  CPU write data.
- `mem_in`  out  DATA_WIDTH  read data to the CPU (registered).
- `load_valid`  in  1  loader write request.
- `load_addr`  in  ADDR_WIDTH  loader address.
- `load_data`  in  DATA_WIDTH  loader data.
- `load_ready`  out  1  loader write accepted this cycle.
- `ready`  out  1  clear sequence finished; memory is serving.
- `wr_count`  out  16  number of accepted writes (CPU plus loader) since reset; saturates at 16'hFFFF.

## Operation
- FSM states:
  - `CLEAR`: entered on reset. A clear pointer starts at 0 and writes 0 to one address per cycle. After writing address 2^ADDR_WIDTH−1, the FSM moves to `SERVE`.
  - `SERVE`: terminal state; left only by reset.
- In `CLEAR`:
  - CPU writes and loader requests are ignored.
  - `mem_in` = 0, `load_ready` = 0, `ready` = 0.
  - Clear writes are not counted in `wr_count`.
- In `SERVE`, every cycle:
  - CPU write: if `mem_we`=1, write `mem_data` to `mem[mem_addr]`.
  - Loader write: if `load_valid`=1 and `mem_we`=0, write `load_data` to `mem[load_addr]` and assert `load_ready`=1 (combinational, same cycle). If `mem_we`=1, `load_ready`=0 and the loader holds its request (valid/ready handshake: transfer happens only on a cycle with valid and ready both high).
  - Read: `mem_in` ← `mem[mem_addr]` at the edge, on every cycle, whether or not a write occurs.
  - Read/write collision: read is write-first. If a write is accepted in the same cycle to the same address `mem_addr` reads, `mem_in` returns the newly written data. This applies to both CPU and loader writes.
  - `wr_count` increments by 1 per accepted write (at most one per cycle) and saturates at 16'hFFFF.
- Width rules: addresses wrap naturally in ADDR_WIDTH bits; no out-of-range addresses exist. The clear pointer is ADDR_WIDTH+1 bits so termination is detected cleanly.

## Timing
- Reset values: `mem_in`=0, `load_ready`=0, `ready`=0, `wr_count`=0, FSM=`CLEAR`, clear pointer=0.
- Clear duration: exactly 2^ADDR_WIDTH cycles after reset deasserts (64 at default). `ready` rises on the edge after the last clear write.
- Read latency: 1 cycle. Address presented before edge N produces `mem_in` valid after edge N.
- Write latency: data is visible to a read of the same address issued in the same cycle (write-first), and to all later reads.
- Reset asserted mid-operation (including mid-`CLEAR`): immediate return to reset values. The clear restarts from address 0, and array contents are re-zeroed by the new sequence.
- Loader request held across a CPU write cycle: accepted on the first subsequent cycle with `mem_we`=0. Data and address must be held stable while waiting.

## Structure
- Package `mem_pkg`: state enum `mem_state_t {CLEAR, SERVE}` and the constant `WR_COUNT_MAX = 16'hFFFF`.
- Sub-module `mem_array`: single-write-port, single-registered-read-port storage with write-first collision behaviour. Write arbitration (clear / CPU / loader), FSM and counter live in `mem_responder`.

## Test plan
- Reset, then wait for `ready`: `ready` rises exactly 64 cycles after `rst` falls. Reading addresses 0, 31 and 63 returns 0. `wr_count`=0.
- CPU write 16'hBEEF to address 5, then read address 5: `mem_in`=16'hBEEF one cycle after the read address. Write with a same-cycle read of address 5 also returns 16'hBEEF (write-first).
- Loader writes 16'h1234 to address 10 while `mem_we`=1 for 3 cycles: `load_ready`=0 for those 3 cycles, then 1 on the 4th. A read of address 10 afterwards gives 16'h1234. `wr_count` increases by 4 (3 CPU writes + 1 load).
- During `CLEAR`, drive `mem_we`=1 to address 0 with 16'hFFFF and `load_valid`=1: both are ignored. After `ready`, address 0 reads 0 and `wr_count`=0.
- Assert `rst` at cycle 20 of the clear sequence, with the array pre-written in an earlier SERVE phase: outputs return to reset values immediately. After the new 64-cycle clear, all previously written addresses read 0.
- Force `wr_count` near saturation by performing 65535 writes, then 2 more: `wr_count` holds at 16'hFFFF.
